// File: rtl/fifo_stream_reader_pkg.sv
// fifo_stream_reader_pkg: DMA read-path width constants shared with the data FIFO.
package fifo_stream_reader_pkg;
  localparam int DMA_DATA_W = 32;
  localparam int DMA_LEN_W = 16;
endpackage

// File: rtl/fifo_stream_reader_skid_buf.sv
// stream_skid_buf: 2-entry in-order buffer; head in r_d0, writes land at the first free slot after any pop.
module stream_skid_buf
  import fifo_stream_reader_pkg::*;
#(
  parameter int W = DMA_DATA_W + 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_wr,
  input  logic [W-1:0] i_wdata,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic [1:0]   o_occ
);
  logic [W-1:0] r_d0, r_d1;
  logic [1:0]   r_occ;
  logic [1:0]   w_idx;
  assign w_idx  = r_occ - {1'b0, i_pop};
  assign o_head = r_d0;
  assign o_occ  = r_occ;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_d0  <= '0;
      r_d1  <= '0;
      r_occ <= '0;
    end else begin
      r_occ <= w_idx + {1'b0, i_wr};
      if (i_wr && w_idx == 2'd0) r_d0 <= i_wdata;
      else if (i_pop) r_d0 <= r_d1;
      if (i_wr && w_idx == 2'd1) r_d1 <= i_wdata;
    end
  end
endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: pops a registered-output FIFO into a valid/ready stream with m_last framing.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int BITS_WIDTH = DMA_DATA_W,
  parameter int BITS_LEN   = DMA_LEN_W
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic [BITS_LEN-1:0]   cfg_len,
  input  logic [BITS_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic [BITS_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  o_busy
);
  logic                r_inflight;
  logic [BITS_LEN-1:0] r_cnt, r_len, w_len;
  logic                w_pop, w_last;
  logic [1:0]          w_occ;
  logic [2:0]          w_credit;
  logic [BITS_WIDTH:0] w_head;
  assign w_pop    = m_valid & m_ready;
  // slots that will be committed after this edge; a new read is only safe below 2
  assign w_credit = {1'b0, w_occ} + {2'b0, r_inflight} - {2'b0, w_pop};
  assign fifo_rd_en = i_rst_n & i_en & ~fifo_empty & (w_credit < 3'd2);
  assign w_len    = (r_cnt == '0) ? ((cfg_len == '0) ? BITS_LEN'(1) : cfg_len) : r_len;
  assign w_last   = (r_cnt == w_len - BITS_LEN'(1));
  assign {m_last, m_data} = w_head;
  assign m_valid  = (w_occ != 2'd0);
  assign o_busy   = r_inflight | m_valid;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_inflight <= 1'b0;
      r_cnt      <= '0;
      r_len      <= '0;
    end else begin
      r_inflight <= fifo_rd_en;
      if (r_inflight) begin
        r_len <= w_len;
        r_cnt <= w_last ? '0 : r_cnt + BITS_LEN'(1);
      end
    end
  end
  stream_skid_buf #(.W(BITS_WIDTH + 1)) u_buf (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_wr    (r_inflight),
    .i_wdata ({w_last, fifo_dout}),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_occ   (w_occ)
  );
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: FIFO model plus queue-based stream model checked every cycle, with directed literal checks.
module tb_fifo_stream_reader;
  logic        i_clk = 0;
  logic        i_rst_n = 0;
  logic        i_en = 0;
  logic [15:0] cfg_len = 16'd4;
  logic [31:0] fifo_dout = 0;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [31:0] m_data;
  logic        m_valid, m_last;
  logic        m_ready = 0;
  logic        o_busy;

  fifo_stream_reader dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .cfg_len(cfg_len),
    .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  // FIFO model: registered dout, one-cycle latency, flushed by system reset when requested
  logic [31:0] mem [0:255];
  int          wp = 0;
  int          rp = 0;
  logic        rd_q = 0;
  logic        flush = 0;
  assign fifo_empty = (rp == wp);
  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_q <= 0;
      if (flush) rp <= wp;
    end else begin
      rd_q <= fifo_rd_en;
      if (fifo_rd_en) begin
        fifo_dout <= mem[rp];
        rp <= rp + 1;
      end
    end
  end

  int          nchk = 0, nerr = 0, cyc_n = 0, nrd = 0;
  logic [31:0] q_d[$];
  bit          q_l[$];
  int          lg_d[$], lg_c[$];
  bit          lg_l[$];
  int          pos = 0, mlen = 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input int v);
    mem[wp] = v;
    wp++;
  endtask

  // Per-cycle comparison against the model; q_d/q_l hold exactly the words buffered in the DUT.
  task automatic compare();
    bit exp_v, pop, exp_rd, lst;
    if (!i_rst_n) begin
      chk("rst_valid", m_valid, 0);
      chk("rst_last", m_last, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_data", m_data, 0);
      chk("rst_rd", fifo_rd_en, 0);
      q_d.delete();
      q_l.delete();
      pos = 0;
    end else begin
      exp_v  = q_d.size() != 0;
      pop    = exp_v && m_ready;
      exp_rd = i_en && !fifo_empty && (q_d.size() + int'(rd_q) - int'(pop) < 2);
      chk("valid", m_valid, exp_v);
      chk("busy", o_busy, exp_v || rd_q);
      chk("rd_en", fifo_rd_en, exp_rd);
      if (fifo_rd_en && fifo_empty) chk("rd_empty", 1, 0);
      if (exp_v && m_valid) begin
        chk("data", m_data, q_d[0]);
        chk("last", m_last, q_l[0]);
      end
      if (pop) begin
        lg_d.push_back(q_d.pop_front());
        lg_l.push_back(q_l.pop_front());
        lg_c.push_back(cyc_n);
      end
      if (rd_q) begin
        if (pos == 0) mlen = (cfg_len == 0) ? 1 : int'(cfg_len);
        lst = (pos == mlen - 1);
        pos = lst ? 0 : pos + 1;
        q_d.push_back(fifo_dout);
        q_l.push_back(lst);
      end
      if (fifo_rd_en) nrd++;
    end
  endtask

  task automatic cyc();
    @(negedge i_clk);
    compare();
    @(posedge i_clk);
    #2;
    cyc_n++;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 40 && o_busy; k++) cyc();
    chk("idle_timeout", o_busy, 0);
  endtask

  initial begin
    int base, nrd0;
    i_en = 1;
    for (int i = 0; i < 16; i++) push(i);
    repeat (3) cyc();
    chk("rst_hold_rd", fifo_rd_en, 0);
    i_rst_n = 1;
    #1;
    chk("lat_rd", fifo_rd_en, 1);
    cyc();
    chk("lat_v1", m_valid, 0);
    cyc();
    chk("lat_v2", m_valid, 1);
    chk("lat_d", m_data, 0);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("bp_rd", fifo_rd_en, 0);
      chk("bp_data", m_data, 0);
    end
    m_ready = 1;
    base = lg_d.size();
    for (int i = 0; i < 40 && lg_d.size() - base < 16; i++) cyc();
    chk("str_cnt", lg_d.size() - base, 16);
    if (lg_d.size() - base >= 16)
      for (int i = 0; i < 16; i++) begin
        chk("str_d", lg_d[base+i], i);
        chk("str_l", lg_l[base+i], (i % 4) == 3);
        chk("str_gap", lg_c[base+i] - lg_c[base], i);
      end
    wait_idle();
    nrd0 = nrd;
    push(32'h55);
    repeat (6) cyc();
    chk("emp_nrd", nrd - nrd0, 1);
    chk("emp_busy", o_busy, 0);
    chk("emp_d", lg_d[lg_d.size()-1], 32'h55);
    for (int i = 0; i < 3; i++) push(32'h56 + i);
    repeat (6) cyc();
    chk("pkt_end", lg_l[lg_l.size()-1], 1);
    i_en = 0;
    cfg_len = 0;
    for (int i = 0; i < 4; i++) push(200 + i);
    cyc();
    i_en = 1;
    cyc();
    i_en = 0;
    base = lg_d.size();
    nrd0 = nrd;
    repeat (6) cyc();
    chk("en_cnt", lg_d.size() - base, 1);
    chk("en_nrd", nrd - nrd0, 0);
    if (lg_d.size() > base) begin
      chk("en_d", lg_d[base], 200);
      chk("en_l", lg_l[base], 1);
    end
    i_en = 1;
    base = lg_d.size();
    repeat (8) cyc();
    chk("len0_cnt", lg_d.size() - base, 3);
    if (lg_d.size() - base >= 3)
      for (int i = 0; i < 3; i++) begin
        chk("len0_d", lg_d[base+i], 201 + i);
        chk("len0_l", lg_l[base+i], 1);
      end
    cfg_len = 5;
    m_ready = 0;
    for (int i = 0; i < 6; i++) push(300 + i);
    repeat (4) cyc();
    chk("mid_valid", m_valid, 1);
    chk("mid_d", m_data, 300);
    #1;
    flush = 1;
    i_rst_n = 0;
    #1;
    chk("ar_valid", m_valid, 0);
    chk("ar_busy", o_busy, 0);
    chk("ar_data", m_data, 0);
    chk("ar_last", m_last, 0);
    chk("ar_rd", fifo_rd_en, 0);
    repeat (2) cyc();
    flush = 0;
    cfg_len = 3;
    for (int i = 0; i < 6; i++) push(400 + i);
    m_ready = 1;
    i_rst_n = 1;
    base = lg_d.size();
    repeat (12) cyc();
    chk("rr_cnt", lg_d.size() - base, 6);
    if (lg_d.size() - base >= 6)
      for (int i = 0; i < 6; i++) begin
        chk("rr_d", lg_d[base+i], 400 + i);
        chk("rr_l", lg_l[base+i], (i % 3) == 2);
      end
    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end
endmodule
